tt_mux_sel_sched: RTL and testbench
===================================

# tt_mux_sel_sched

Sequencer and arbiter for the mux control interface (`ctrl_sel_rst_n`, `ctrl_sel_inc`, `ctrl_ena`). It accepts design-select requests from two requesters: port 0 is the boot-time auto-selector and port 1 is the manual/commander path. For each request it drives the shift-chain reset and increment pulse train with programmable widths, then enables the selected design. It sits between the selection sources and the mux controller, and is the only driver of the ctrl signals.

## Interface
- `ADDR_W`, 10, width of design address and position counter
- `RST_W`, 4, cycles `ctrl_sel_rst_n` is held low during a chain reset (≥1)
- `PULSE_W`, 2, cycles per high phase and per low phase of each `ctrl_sel_inc` pulse (≥1)

- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req0_addr` / `req0_ready`  in / in / out  1 / ADDR_W / 1  high-priority request, valid/ready handshake
- `req1_valid` / `req1_addr` / `req1_ready`  in / in / out  1 / ADDR_W / 1  low-priority request, valid/ready handshake
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a request completes
- `grant`  out  1  requester index of the last accepted request
- `cur_addr`  out  ADDR_W  current chain position
- `ctrl_sel_rst_n`  out  1  chain reset, active low
- `ctrl_sel_inc`  out  1  chain increment pulse
- `ctrl_ena`  out  1  enable for the selected design

## Operation
- Reset values: `ctrl_sel_rst_n`=0, `ctrl_sel_inc`=0, `ctrl_ena`=0, `done`=0, `busy`=0, `grant`=0, `cur_addr`=0, internal `pos_known`=0, state IDLE. All ctrl outputs are registered.
- Readies are combinational.
  - `req0_ready` = (state==IDLE).
  - `req1_ready` = (state==IDLE) & !`req0_valid`.
  - Acceptance is valid & ready. On acceptance, address and `grant` are latched.
  - Requesters hold valid and addr stable until ready.
- Path selection at accept, with target T:
  - `pos_known` & `ctrl_ena` & T==`cur_addr` → HIT path.
  - `pos_known` & T>`cur_addr` → INC path (no chain reset).
  - Otherwise → FULL path.
- States:
  - IDLE: wait for acceptance.
  - DISABLE: one cycle, `ctrl_ena`←0.
  - CHAIN_RST: `ctrl_sel_rst_n`=0 for RST_W cycles, then 1. `cur_addr`←0 and `pos_known`←1 on exit.
  - INC_HI: `ctrl_sel_inc`=1 for PULSE_W cycles.
  - INC_LO: `ctrl_sel_inc`=0 for PULSE_W cycles. `cur_addr`+1 on exit.
  - ENABLE: `ctrl_ena`←1 and `done` pulses; return to IDLE.
- Transitions:
  - FULL: IDLE→DISABLE→CHAIN_RST→(INC_HI→INC_LO)×T→ENABLE.
  - INC: IDLE→DISABLE→(INC_HI→INC_LO)×(T−`cur_addr`)→ENABLE.
  - HIT: IDLE→ENABLE. `ctrl_ena` stays 1 with no glitch.
- Arithmetic:
  - `cur_addr` only counts up to T ≤ 2^ADDR_W−1 and never wraps.
  - T<`cur_addr` always takes the FULL path.
  - After CHAIN_RST exits, `ctrl_sel_rst_n` stays 1 until the next FULL path.
- `ctrl_sel_inc` and a low `ctrl_sel_rst_n` are never asserted in the same cycle.
- `ctrl_ena` is never 1 while `ctrl_sel_inc`=1 or `ctrl_sel_rst_n`=0.

## Timing
- Acceptance is at cycle t0.
  - DISABLE occupies t0+1; `ctrl_ena` reads 0 from t0+2.
  - FULL: `ctrl_sel_rst_n`=0 during t0+2..t0+1+RST_W. `done` and `ctrl_ena`=1 at t0+2+RST_W+2·PULSE_W·T.
  - INC: `done` at t0+2+2·PULSE_W·(T−`cur_addr`).
  - HIT: `done` at t0+1.
- Simultaneous valids in IDLE: port 0 wins and port 1 stays unaccepted.
- Requests arriving while busy are stalled, not dropped.
- Async reset mid-operation: all outputs return to reset values immediately.
  - The in-flight request is discarded with no `done`.
  - `pos_known`=0, so the next request takes the FULL path.

## Structure
- Shared package `tt_mux_ctrl_pkg` contains:
  - the state enum (IDLE, DISABLE, CHAIN_RST, INC_HI, INC_LO, ENABLE);
  - default ADDR_W / RST_W / PULSE_W constants;
  - requester index constants REQ_BOOT=0, REQ_USER=1.
- One sub-module, `tt_phase_timer`: a loadable down-counter.
  - Inputs: `load`, `len`.
  - Output: `expire` one cycle before the phase ends.
  - Shared by the CHAIN_RST, INC_HI and INC_LO phases.

## Test plan
All scenarios use defaults (RST_W=4, PULSE_W=2).
- After reset, `req0` with addr=3 accepted at t0 → `ctrl_sel_rst_n` low through t0+5; `ctrl_sel_inc` high at t0+6..7, t0+10..11, t0+14..15; `ctrl_ena`=1, `done` and `cur_addr`=3 at t0+18.
- From addr 3 enabled, `req1` with addr=5 → no chain reset; `ctrl_ena` 0 from t0+2; 2 inc pulses; `done` at t0+10 with `cur_addr`=5.
- From 5, `req1` with addr=2 → FULL path; `done` at t0+2+4+8=t0+14.
- From 5 enabled, `req0` with addr=5 → `done` at t0+1; `ctrl_ena` never drops.
- `req0_valid` and `req1_valid` both asserted in IDLE → port 0 served, `grant`=0; port 1 accepted in the IDLE cycle after `done`, `grant`=1.
- `rst_n` pulsed low mid INC_HI → `ctrl_sel_inc`, `ctrl_ena`, `ctrl_sel_rst_n` read 0 asynchronously; no `done`; next `req0` with addr=1 takes the FULL path, `done` at t0+10.

Source files
------------

// File: rtl/tt_mux_ctrl_pkg.sv
// tt_mux_ctrl_pkg: shared state encoding and defaults for the mux select sequencer.
// Rev 1.0
`default_nettype none

package tt_mux_ctrl_pkg;

  localparam int DEF_ADDR_W  = 10;
  localparam int DEF_RST_W   = 4;
  localparam int DEF_PULSE_W = 2;

  localparam logic REQ_BOOT = 1'b0;
  localparam logic REQ_USER = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DISABLE   = 3'd1,
    S_CHAIN_RST = 3'd2,
    S_INC_HI    = 3'd3,
    S_INC_LO    = 3'd4,
    S_ENABLE    = 3'd5
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tt_phase_timer.sv
// tt_phase_timer: loadable down-counter; expire marks the last cycle of a phase.
// Rev 1.0
`default_nettype none

module tt_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  // Loaded on the edge entering a phase, so a phase of len cycles starts at len-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= len - W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/tt_mux_sel_sched.sv
// tt_mux_sel_sched: two-port arbiter driving the mux chain reset/increment/enable sequence.
// Rev 1.0
`default_nettype none

module tt_mux_sel_sched
  import tt_mux_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int RST_W   = DEF_RST_W,
  parameter int PULSE_W = DEF_PULSE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              busy,
  output logic              done,
  output logic              grant,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int TMR_W = $clog2(max2(RST_W, PULSE_W) + 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_target;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W-1:0] w_req_addr;
  logic              r_full;
  logic              r_pos_known;
  logic              r_grant;
  logic              r_done;
  logic              r_inc;
  logic              r_sel_rst_n;
  logic              r_ena;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_accept;
  logic              w_hit;
  logic              w_inc_path;
  logic              w_last_inc;
  logic              w_tmr_load;
  logic              w_tmr_exp;
  logic [TMR_W-1:0]  w_tmr_len;

  assign req0_ready = (r_state == S_IDLE);
  assign req1_ready = (r_state == S_IDLE) & ~req0_valid;
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;
  assign w_accept   = w_acc0 | w_acc1;
  assign w_req_addr = w_acc0 ? req0_addr : req1_addr;

  assign w_hit      = r_pos_known & r_ena & (w_req_addr == r_cur_addr);
  assign w_inc_path = r_pos_known & (w_req_addr > r_cur_addr);
  // Target never exceeds the max address, so this increment cannot wrap.
  assign w_last_inc = ((r_cur_addr + ADDR_W'(1)) == r_target);

  // Every timed phase is entered through a state change, which reloads the timer.
  assign w_tmr_load = (w_next != r_state);
  assign w_tmr_len  = (w_next == S_CHAIN_RST) ? TMR_W'(RST_W) : TMR_W'(PULSE_W);

  tt_phase_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_tmr_load),
    .len    (w_tmr_len),
    .expire (w_tmr_exp)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = w_hit ? S_ENABLE : S_DISABLE;
      S_DISABLE:   w_next = r_full ? S_CHAIN_RST : S_INC_HI;
      S_CHAIN_RST: if (w_tmr_exp) w_next = (r_target == '0) ? S_ENABLE : S_INC_HI;
      S_INC_HI:    if (w_tmr_exp) w_next = S_INC_LO;
      S_INC_LO:    if (w_tmr_exp) w_next = w_last_inc ? S_ENABLE : S_INC_HI;
      S_ENABLE:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_cur_addr  <= '0;
      r_full      <= 1'b0;
      r_pos_known <= 1'b0;
      r_grant     <= REQ_BOOT;
      r_done      <= 1'b0;
      r_inc       <= 1'b0;
      r_sel_rst_n <= 1'b0;
      r_ena       <= 1'b0;
    end else begin
      r_state <= w_next;
      // Outputs decode the next state so they line up with the state they describe.
      r_done  <= (w_next == S_ENABLE);
      r_inc   <= (w_next == S_INC_HI);

      if (w_next == S_CHAIN_RST) begin
        r_sel_rst_n <= 1'b0;
      end else if (r_state == S_CHAIN_RST) begin
        r_sel_rst_n <= 1'b1;
      end

      if (w_next == S_ENABLE) begin
        r_ena <= 1'b1;
      end else if (r_state == S_DISABLE) begin
        r_ena <= 1'b0;
      end

      if ((r_state == S_IDLE) && w_accept) begin
        r_target <= w_req_addr;
        r_grant  <= w_acc0 ? REQ_BOOT : REQ_USER;
        r_full   <= ~(w_hit | w_inc_path);
      end

      if ((r_state == S_CHAIN_RST) && w_tmr_exp) begin
        r_cur_addr  <= '0;
        r_pos_known <= 1'b1;
      end else if ((r_state == S_INC_LO) && w_tmr_exp) begin
        r_cur_addr <= r_cur_addr + ADDR_W'(1);
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign grant          = r_grant;
  assign cur_addr       = r_cur_addr;
  assign ctrl_sel_rst_n = r_sel_rst_n;
  assign ctrl_sel_inc   = r_inc;
  assign ctrl_ena       = r_ena;

endmodule

`default_nettype wire

// File: tb/tb_tt_mux_sel_sched.sv
// tb_tt_mux_sel_sched: randomized scoreboard bench for the mux select sequencer.
// Rev 1.0
`default_nettype none

module tb_tt_mux_sel_sched;

  localparam int AW = 10;
  localparam int RW = 4;
  localparam int PW = 2;
  localparam int MAXA = (1 << AW) - 1;

  logic          clk;
  logic          rst_n;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic          req1_ready;
  logic          busy;
  logic          done;
  logic          grant;
  logic [AW-1:0] cur_addr;
  logic          ctrl_sel_rst_n;
  logic          ctrl_sel_inc;
  logic          ctrl_ena;

  tt_mux_sel_sched #(
    .ADDR_W  (AW),
    .RST_W   (RW),
    .PULSE_W (PW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_ready     (req1_ready),
    .busy           (busy),
    .done           (done),
    .grant          (grant),
    .cur_addr       (cur_addr),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one accepted request
  typedef struct {
    int   addr;
    int   grant;
    int   done_cyc;
    int   pulses;
    int   rst_low;
    logic drop;
  } exp_t;

  exp_t sb[$];

  // Reference model: what the chain looks like from outside
  logic m_pos  = 1'b0;
  logic m_ena  = 1'b0;
  logic m_rstn = 1'b0;
  int   m_cur  = 0;

  task automatic model_reset();
    m_pos = 1'b0; m_ena = 1'b0; m_rstn = 1'b0; m_cur = 0;
  endtask

  task automatic push_exp(input int p, input int a, input int t0);
    exp_t e;
    e.addr  = a;
    e.grant = p;
    if (m_pos && m_ena && a == m_cur) begin
      e.pulses = 0; e.rst_low = 0; e.drop = 1'b0; e.done_cyc = t0 + 1;
    end else if (m_pos && a > m_cur) begin
      e.pulses = a - m_cur; e.rst_low = 0; e.drop = 1'b1;
      e.done_cyc = t0 + 2 + 2 * PW * e.pulses;
    end else begin
      e.pulses = a; e.drop = 1'b1;
      e.rst_low = RW + (m_rstn ? 0 : 1);
      e.done_cyc = t0 + 2 + RW + 2 * PW * a;
      m_rstn = 1'b1;
    end
    m_pos = 1'b1; m_ena = 1'b1; m_cur = a;
    sb.push_back(e);
  endtask

  // Monitor: observes the DUT every cycle and retires scoreboard entries on done
  int   cnt_pulses = 0;
  int   cnt_hi     = 0;
  int   cnt_rlow   = 0;
  logic seen_drop  = 1'b0;
  logic prev_inc   = 1'b0;
  exp_t me;

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_pulses = 0; cnt_hi = 0; cnt_rlow = 0; seen_drop = 1'b0; prev_inc = 1'b0;
    end else begin
      chk("req0_ready", req0_ready, (sb.size() == 0));
      chk("busy", busy, (sb.size() != 0));
      if (req0_valid) chk("req1_ready_prio", req1_ready, 0);
      chk("inc_during_rst", ctrl_sel_inc & ~ctrl_sel_rst_n, 0);
      chk("ena_during_chain", ctrl_ena & (ctrl_sel_inc | ~ctrl_sel_rst_n), 0);
      if (ctrl_sel_inc && !prev_inc) cnt_pulses++;
      if (ctrl_sel_inc) cnt_hi++;
      if (busy && !ctrl_sel_rst_n) cnt_rlow++;
      if (!ctrl_ena) seen_drop = 1'b1;
      prev_inc = ctrl_sel_inc;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("done_cycle", cyc, me.done_cyc);
          chk("cur_addr", cur_addr, me.addr);
          chk("grant", grant, me.grant);
          chk("ena_at_done", ctrl_ena, 1);
          chk("inc_pulses", cnt_pulses, me.pulses);
          chk("inc_hi_cycles", cnt_hi, me.pulses * PW);
          chk("rst_low_cycles", cnt_rlow, me.rst_low);
          chk("ena_dropped", seen_drop, me.drop);
        end
        cnt_pulses = 0; cnt_hi = 0; cnt_rlow = 0; seen_drop = 1'b0;
      end
    end
  end

  task automatic send(input int p, input int a);
    bit ok = 1'b0;
    if (p == 0) begin req0_valid = 1'b1; req0_addr = AW'(a); end
    else        begin req1_valid = 1'b1; req1_addr = AW'(a); end
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk); #1;
      if ((p == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
    end
    if (ok) push_exp(p, a, cyc);
    else chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic send_both(input int a0, input int a1);
    bit g0 = 1'b0, g1 = 1'b0;
    int first = -1;
    req0_valid = 1'b1; req0_addr = AW'(a0);
    req1_valid = 1'b1; req1_addr = AW'(a1);
    for (int n = 0; n < 12000 && !(g0 && g1); n++) begin
      @(negedge clk); #1;
      if (!g0 && req0_ready) begin
        push_exp(0, a0, cyc); g0 = 1'b1; if (first < 0) first = 0;
        @(posedge clk); #1; req0_valid = 1'b0;
      end else if (!g1 && req1_ready) begin
        push_exp(1, a1, cyc); g1 = 1'b1; if (first < 0) first = 1;
        @(posedge clk); #1; req1_valid = 1'b0;
      end
    end
    chk("both_accepted", g0 & g1, 1);
    chk("first_winner", first, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 6000; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rst_n"}, ctrl_sel_rst_n, 0);
    chk({tag, "_inc"}, ctrl_sel_inc, 0);
    chk({tag, "_ena"}, ctrl_ena, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_cur"}, cur_addr, 0);
  endtask

  initial begin
    int a;
    int r;
    bit seen;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_addr = '0;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("post_reset");

    // Directed walk: full, inc, full backwards, inc, hit
    send(0, 3);
    send(1, 5);
    send(1, 2);
    send(0, 5);
    send(0, 5);
    wait_idle();

    // Simultaneous requesters
    send_both(9, 4);
    wait_idle();

    // Async reset in the middle of an increment pulse
    send(0, m_cur + 3);
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (ctrl_sel_inc) begin seen = 1'b1; break; end
    end
    chk("inc_seen_before_reset", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    chk("done_in_reset", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 1);
    wait_idle();

    // Randomized traffic, often issued while the block is still busy
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       a = m_cur;
        1:       a = m_cur + $urandom_range(1, 4);
        2:       a = $urandom_range(0, 12);
        default: a = (m_cur > 0) ? m_cur - 1 : 0;
      endcase
      if (a > MAXA) a = MAXA;
      send($urandom_range(0, 1), a);
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    // Address extremes
    send(1, MAXA);
    send(0, MAXA);
    send(0, 0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
